nexys_starship_break_sched: RTL and testbench



---
 rtl/nexys_starship_break_sched.sv | 195 +++++++++++++++++++
 tb/tb_nexys_starship_break_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_break_sched.sv
// Central shield-break scheduler: picks one unbroken shield at a time via an LFSR,
// holds a one-hot request until the repair SM acknowledges, and ramps difficulty.
module nexys_starship_break_sched #(
   parameter int unsigned MAX_BROKEN    = 2,
   parameter int unsigned INIT_INTERVAL = 8,
   parameter int unsigned MIN_INTERVAL  = 2,
   parameter int unsigned RAMP_EVERY    = 4,
   parameter int unsigned ACK_TIMEOUT   = 16,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       gameover_ctrl,
   input  logic       tick,
   input  logic [3:0] broken,
   output logic [3:0] break_req,
   output logic [3:0] random_hex,
   output logic [7:0] interval,
   output logic [7:0] break_count,
   output logic       q_Idle,
   output logic       q_Count,
   output logic       q_Pick,
   output logic       q_Wait
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned RAMP_W = $clog2(RAMP_EVERY + 1);

   localparam logic [3:0] S_IDLE  = 4'b0001;
   localparam logic [3:0] S_COUNT = 4'b0010;
   localparam logic [3:0] S_PICK  = 4'b0100;
   localparam logic [3:0] S_WAIT  = 4'b1000;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   logic [3:0]        state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [7:0]        interval_q, interval_d;
   logic [7:0]        bcount_q,   bcount_d;
   logic [RAMP_W-1:0] ramp_q,     ramp_d;
   logic [TO_W-1:0]   to_q,       to_d;
   logic [1:0]        g_q,        g_d;
   logic [15:0]       lfsr_q,     lfsr_d;
   logic [3:0]        req_q,      req_d;
   logic [3:0]        hex_q,      hex_d;

   logic [15:0] lfsr_next_c;
   logic [2:0]  pop_c;
   logic        pick_found_c;
   logic [1:0]  pick_g_c;
   logic [1:0]  pick_idx_c;
   logic        skip_c;
   logic        ack_c;
   logic        timeout_c;

   assign lfsr_next_c = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   assign pop_c       = 3'(broken[0]) + 3'(broken[1]) + 3'(broken[2]) + 3'(broken[3]);
   assign skip_c      = (32'(pop_c) >= MAX_BROKEN) || !pick_found_c;
   assign ack_c       = broken[g_q];
   assign timeout_c   = (to_q == TO_W'(ACK_TIMEOUT - 1));

   // First unbroken unit at or above the LFSR candidate, wrapping 3 -> 0.
   always_comb begin
      pick_found_c = 1'b0;
      pick_g_c     = lfsr_q[1:0];
      pick_idx_c   = lfsr_q[1:0];
      for (int i = 0; i < 4; i++) begin
         pick_idx_c = lfsr_q[1:0] + 2'(i);
         if (!pick_found_c && !broken[pick_idx_c]) begin
            pick_found_c = 1'b1;
            pick_g_c     = pick_idx_c;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      interval_d = interval_q;
      bcount_d   = bcount_q;
      ramp_d     = ramp_q;
      to_d       = to_q;
      g_d        = g_q;
      lfsr_d     = lfsr_q;
      req_d      = req_q;
      hex_d      = hex_q;

      if (gameover_ctrl) begin
         state_d    = S_IDLE;
         req_d      = 4'b0000;
         interval_d = 8'(INIT_INTERVAL);
         bcount_d   = 8'd0;
         ramp_d     = '0;
         cnt_d      = '0;
         to_d       = '0;
      end else begin
         if (state_q != S_IDLE) lfsr_d = lfsr_next_c;
         case (state_q)
            S_IDLE: begin
               req_d = 4'b0000;
               if (play_flag) begin
                  state_d = S_COUNT;
                  cnt_d   = interval_q;
               end
            end
            S_COUNT: begin
               if (tick) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_d = S_PICK;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            S_PICK: begin
               if (skip_c) begin
                  state_d = S_COUNT;
                  cnt_d   = interval_q;
               end else begin
                  g_d     = pick_g_c;
                  hex_d   = (lfsr_q[7:4] == 4'h0) ? 4'h1 : lfsr_q[7:4];
                  req_d   = 4'b0001 << pick_g_c;
                  state_d = S_WAIT;
                  to_d    = '0;
               end
            end
            S_WAIT: begin
               if (ack_c) begin
                  req_d    = 4'b0000;
                  state_d  = S_COUNT;
                  bcount_d = (bcount_q == 8'hFF) ? bcount_q : bcount_q + 8'd1;
                  // New difficulty applies to the very next countdown.
                  if (ramp_q == RAMP_W'(RAMP_EVERY - 1)) begin
                     ramp_d     = '0;
                     interval_d = (interval_q > 8'(MIN_INTERVAL)) ? interval_q - 8'd1
                                                                  : 8'(MIN_INTERVAL);
                  end else begin
                     ramp_d = ramp_q + RAMP_W'(1);
                  end
                  cnt_d = interval_d;
               end else if (timeout_c) begin
                  req_d   = 4'b0000;
                  state_d = S_COUNT;
                  cnt_d   = interval_q;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               req_d   = 4'b0000;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         interval_q <= 8'(INIT_INTERVAL);
         bcount_q   <= 8'd0;
         ramp_q     <= '0;
         to_q       <= '0;
         g_q        <= 2'd0;
         lfsr_q     <= LFSR_SEED;
         req_q      <= 4'b0000;
         hex_q      <= 4'h1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         interval_q <= interval_d;
         bcount_q   <= bcount_d;
         ramp_q     <= ramp_d;
         to_q       <= to_d;
         g_q        <= g_d;
         lfsr_q     <= lfsr_d;
         req_q      <= req_d;
         hex_q      <= hex_d;
      end
   end

   assign break_req   = req_q;
   assign random_hex  = hex_q;
   assign interval    = interval_q;
   assign break_count = bcount_q;
   assign q_Idle      = state_q[0];
   assign q_Count     = state_q[1];
   assign q_Pick      = state_q[2];
   assign q_Wait      = state_q[3];

endmodule

// File: tb/tb_nexys_starship_break_sched.sv
// Bench for nexys_starship_break_sched: directed scenarios plus a per-cycle
// comparison against a behavioural game model.
module tb_nexys_starship_break_sched;

   localparam int MAX_BROKEN    = 2;
   localparam int INIT_INTERVAL = 8;
   localparam int MIN_INTERVAL  = 2;
   localparam int RAMP_EVERY    = 4;
   localparam int ACK_TIMEOUT   = 16;

   localparam int ST_IDLE  = 0;
   localparam int ST_COUNT = 1;
   localparam int ST_PICK  = 2;
   localparam int ST_WAIT  = 3;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       play_flag;
   logic       gameover_ctrl;
   logic       tick;
   logic [3:0] broken;
   logic [3:0] break_req;
   logic [3:0] random_hex;
   logic [7:0] interval;
   logic [7:0] break_count;
   logic       q_Idle, q_Count, q_Pick, q_Wait;

   int n_chk  = 0;
   int n_pass = 0;
   bit tick_alt = 1'b0;

   nexys_starship_break_sched #(
      .MAX_BROKEN(MAX_BROKEN), .INIT_INTERVAL(INIT_INTERVAL), .MIN_INTERVAL(MIN_INTERVAL),
      .RAMP_EVERY(RAMP_EVERY), .ACK_TIMEOUT(ACK_TIMEOUT), .LFSR_SEED(16'hACE1)
   ) dut (
      .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
      .tick(tick), .broken(broken), .break_req(break_req), .random_hex(random_hex),
      .interval(interval), .break_count(break_count),
      .q_Idle(q_Idle), .q_Count(q_Count), .q_Pick(q_Pick), .q_Wait(q_Wait)
   );

   always #5 Clk = ~Clk;

   // Game-level model: acks counts acknowledged breaks since game start.
   typedef struct {
      int          st;
      int          cnt;
      int          acks;
      int          waited;
      int          g;
      logic [15:0] lfsr;
      logic [3:0]  req;
      logic [3:0]  hex;
   } model_t;

   model_t m;

   function automatic int ival(input int acks);
      int v;
      v = INIT_INTERVAL - acks / RAMP_EVERY;
      return (v < MIN_INTERVAL) ? MIN_INTERVAL : v;
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
      logic [15:0] y;
      y = x >> 1;
      if (x[0]) y = y ^ 16'hB400;
      return y;
   endfunction

   function automatic model_t m_reset();
      model_t r;
      r.st = ST_IDLE; r.cnt = 0; r.acks = 0; r.waited = 0; r.g = 0;
      r.lfsr = 16'hACE1; r.req = 4'b0000; r.hex = 4'h1;
      return r;
   endfunction

   function automatic model_t mstep(input model_t cur, input logic play, input logic go,
                                    input logic tk, input logic [3:0] brk);
      model_t n;
      int c;
      int k;
      n = cur;
      if (go) begin
         n.st = ST_IDLE; n.req = 4'b0000; n.acks = 0; n.cnt = 0; n.waited = 0;
         return n;
      end
      if (cur.st != ST_IDLE) n.lfsr = lfsr_adv(cur.lfsr);
      if (cur.st == ST_IDLE) begin
         n.req = 4'b0000;
         if (play) begin n.st = ST_COUNT; n.cnt = ival(cur.acks); end
      end else if (cur.st == ST_COUNT) begin
         if (tk) begin
            n.cnt = cur.cnt - 1;
            if (n.cnt == 0) n.st = ST_PICK;
         end
      end else if (cur.st == ST_PICK) begin
         c = int'(cur.lfsr % 16'd4);
         k = 0;
         while (k < 4 && brk[(c + k) % 4]) k++;
         if ($countones(brk) >= MAX_BROKEN || k == 4) begin
            n.st = ST_COUNT; n.cnt = ival(cur.acks);
         end else begin
            n.g   = (c + k) % 4;
            n.hex = 4'((cur.lfsr >> 4) % 16'd16);
            if (n.hex == 4'h0) n.hex = 4'h1;
            n.req = 4'(1 << n.g);
            n.st  = ST_WAIT;
            n.waited = 0;
         end
      end else begin
         n.waited = cur.waited + 1;
         if (brk[cur.g]) begin
            n.acks = cur.acks + 1;
            n.req = 4'b0000; n.st = ST_COUNT; n.cnt = ival(n.acks);
         end else if (n.waited == ACK_TIMEOUT) begin
            n.req = 4'b0000; n.st = ST_COUNT; n.cnt = ival(cur.acks);
         end
      end
      return n;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) m <= m_reset();
      else       m <= mstep(m, play_flag, gameover_ctrl, tick, broken);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge Clk) begin
      chk("state_onehot", 32'({q_Wait, q_Pick, q_Count, q_Idle}),
          32'(4'b0001 << m.st));
      chk("break_req", 32'(break_req), 32'(m.req));
      chk("random_hex", 32'(random_hex), 32'(m.hex));
      chk("interval", 32'(interval), 32'(ival(m.acks)));
      chk("break_count", 32'(break_count), 32'((m.acks > 255) ? 255 : m.acks));
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
      if (tick_alt) tick = ~tick;
   endtask

   task automatic wait_for_wait(input int budget);
      int n;
      n = 0;
      while (!q_Wait && n < budget) begin
         cyc();
         n++;
      end
      chk("wait_reached", 32'(q_Wait), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int exp_iv;
      Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0; tick = 1'b0; broken = 4'b0000;
      cyc(); cyc();
      Reset = 1'b0;
      chk("rst_idle", 32'(q_Idle), 32'd1);
      chk("rst_req", 32'(break_req), 32'h0);
      chk("rst_hex", 32'(random_hex), 32'h1);
      chk("rst_interval", 32'(interval), 32'd8);
      chk("rst_count", 32'(break_count), 32'd0);

      // Start a game with a tick every cycle.
      play_flag = 1'b1; tick = 1'b1;
      cyc();
      chk("start_count", 32'(q_Count), 32'd1);
      repeat (8) cyc();
      chk("first_pick", 32'(q_Pick), 32'd1);
      chk("model_lfsr_pick", 32'(m.lfsr), 32'hC2C4);
      cyc();
      chk("first_wait", 32'(q_Wait), 32'd1);
      chk("first_req", 32'(break_req), 32'h1);
      chk("first_hex", 32'(random_hex), 32'hC);

      // Acknowledge unit 0.
      broken = 4'b0001;
      cyc();
      chk("ack_req_drop", 32'(break_req), 32'h0);
      chk("ack_count", 32'(break_count), 32'd1);
      chk("ack_state", 32'(q_Count), 32'd1);

      // Two broken at expiry: pick is skipped after a full reload of 8.
      broken = 4'b0011;
      repeat (8) cyc();
      chk("skip_pick", 32'(q_Pick), 32'd1);
      cyc();
      chk("skip_state", 32'(q_Count), 32'd1);
      chk("skip_req", 32'(break_req), 32'h0);
      chk("skip_count", 32'(break_count), 32'd1);

      // Fresh start with unit 0 broken: candidate 0 rotates to unit 1.
      Reset = 1'b1;
      cyc();
      Reset = 1'b0; broken = 4'b0001;
      cyc();
      repeat (8) cyc();
      chk("rot_pick", 32'(q_Pick), 32'd1);
      cyc();
      chk("rot_req", 32'(break_req), 32'h2);
      chk("rot_hex", 32'(random_hex), 32'hC);

      // Unit 1 never acknowledges: request abandoned after ACK_TIMEOUT cycles.
      n = 0;
      while (q_Wait && n < 40) begin
         n++;
         cyc();
      end
      chk("timeout_len", 32'(n), 32'd16);
      chk("timeout_state", 32'(q_Count), 32'd1);
      chk("timeout_req", 32'(break_req), 32'h0);
      chk("timeout_count", 32'(break_count), 32'd0);

      // Asynchronous reset mid-WAIT drops the request immediately.
      wait_for_wait(60);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_req", 32'(break_req), 32'h0);
      chk("async_rst_idle", 32'(q_Idle), 32'd1);
      cyc();
      Reset = 1'b0; broken = 4'b0000; tick_alt = 1'b1;

      // Acked breaks ramp the interval down to its floor.
      for (int k = 1; k <= 28; k++) begin
         wait_for_wait(100);
         cyc();
         broken = break_req;
         cyc();
         broken = 4'b0000;
         exp_iv = 8 - k / 4;
         if (exp_iv < 2) exp_iv = 2;
         chk("ramp_interval", 32'(interval), 32'(exp_iv));
         chk("ramp_count", 32'(break_count), 32'(k));
      end

      // Gameover in the same cycle as an ack: gameover wins.
      wait_for_wait(100);
      broken = break_req; gameover_ctrl = 1'b1;
      cyc();
      chk("go_idle", 32'(q_Idle), 32'd1);
      chk("go_interval", 32'(interval), 32'd8);
      chk("go_count", 32'(break_count), 32'd0);
      chk("go_req", 32'(break_req), 32'h0);
      gameover_ctrl = 1'b0; play_flag = 1'b0; broken = 4'b0000;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
